decode_stage: RTL and testbench
===============================

# decode_stage

Instruction-decode stage of the MIPS datapath: the producer side of the execute-stage operand interface (RF_A, RF_B, Immed). It holds the 32x32 register file, extracts register fields, extends the immediate, accepts write-back from the last stage, and presents registered operands to the ALU stage through an ID/EX latch with stall and flush control.

## Interface
- No parameters; widths fixed: 32-bit data, 5-bit register addresses, 32 registers.
- Clk  input  1  rising-edge clock
- Rst  input  1  synchronous, active-high reset
- Instr  input  32  instruction word: opcode [31:26], rs [25:21], rd [20:16], rt [15:11], immed [15:0]
- Instr_valid  input  1  Instr is a real instruction (0 = bubble)
- RF_B_sel  input  1  source of read port B address: 0 = rt, 1 = rd
- ImmExt  input  2  immediate mode: 00 zero-extend, 01 sign-extend, 10 sign-extend then <<2, 11 immed<<16 (low half zero)
- Stall  input  1  hold ID/EX latch
- Flush  input  1  load bubble into ID/EX latch
- WB_WrEn  input  1  register-file write enable
- WB_Addr  input  5  write address
- WB_Data  input  32  write data
- RF_A  output  32  latched read port A (rs)
- RF_B  output  32  latched read port B (rt or rd)
- Immed  output  32  latched extended immediate
- Dst_Addr  output  5  latched rd, for write-back addressing downstream
- Out_valid  output  1  latched Instr_valid

## Operation
- Register file: 32 x 32 bits; write on rising Clk when WB_WrEn=1 and WB_Addr != 0; writes to R0 ignored; R0 always reads 0.
- Read port A address = Instr[25:21]; port B address = RF_B_sel ? Instr[20:16] : Instr[15:11]. Reads combinational.
- Write-through bypass: when WB_WrEn=1, WB_Addr != 0 and WB_Addr equals a read address in the same cycle, that port returns WB_Data (not the stale value).
- Immediate: computed combinationally from Instr[15:0] per ImmExt; mode 10 result = {sext[29:0], 2'b00}; mode 11 = {immed, 16'h0000}.
- ID/EX latch update each rising edge, priority: Rst > Flush > Stall > load.
  - Rst: all outputs 0; all 32 registers cleared to 0.
  - Flush: RF_A, RF_B, Immed = 0, Dst_Addr = 0, Out_valid = 0. Register-file write still performed.
  - Stall (no Flush): all latch outputs hold. Register-file write still performed.
  - Otherwise: latch loads bypassed read data, Immed, Instr[20:16], Instr_valid.
- Instr_valid=0 with no Stall/Flush: data still loaded as computed; Out_valid = 0.

## Timing
- Latency: 1 cycle, Instr/controls at edge N -> RF_A/RF_B/Immed/Out_valid valid after edge N+1.
- Write-back: WB data written at edge N is visible to a read in cycle N via bypass, and from storage afterwards.
- Reset values: RF_A, RF_B, Immed = 32'h0; Dst_Addr = 5'd0; Out_valid = 0; all registers 0. Rst asserted mid-stream overrides Stall, Flush and WB_WrEn in that cycle.
- Stall held across a write-back: latched operands stay stale; re-read occurs at the first unstalled edge and picks up the new value.
- Simultaneous Stall and Flush: Flush wins.

## Structure
- Shared package: ImmExt encodings (IMM_ZERO, IMM_SIGN, IMM_SIGN_SH2, IMM_HIGH), instruction field bit positions, REG_ZERO address.
- One sub-module: register_file (32x32, two combinational read ports with write-through bypass, one synchronous write port, synchronous clear on Rst). Immediate extension and ID/EX latch live in decode_stage.

## Test plan
- Reset then read: Rst 1 cycle, Instr with rs=5, rt=7 -> RF_A=0, RF_B=0, Out_valid follows Instr_valid one cycle later.
- Write/read and R0: write R3=32'hDEADBEEF, write R0=32'h1234; read rs=3, rt=0 -> RF_A=32'hDEADBEEF, RF_B=0.
- Bypass: WB_WrEn=1, WB_Addr=9, WB_Data=32'hA5A5A5A5 while Instr rs=9, RF_B_sel=1, rd=9 -> next cycle RF_A=RF_B=32'hA5A5A5A5.
- Immediate modes on immed=16'h8001: 00 -> 32'h00008001, 01 -> 32'hFFFF8001, 10 -> 32'hFFFE0004, 11 -> 32'h80010000.
- Stall/Flush: latch holding RF_A=32'h11; Stall 2 cycles with new Instr -> RF_A stays 32'h11; Stall+Flush -> all outputs 0, Out_valid=0.
- Reset mid-operation: Rst with WB_WrEn=1 to R4 -> R4 reads 0 afterwards, all outputs 0.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared definitions for the instruction-decode stage.
// Immediate modes, instruction field positions and the ID/EX bundle.
package decode_stage_pkg;

  typedef enum logic [1:0] {
    IMM_ZERO     = 2'b00,
    IMM_SIGN     = 2'b01,
    IMM_SIGN_SH2 = 2'b10,
    IMM_HIGH     = 2'b11
  } imm_ext_e;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RD_MSB  = 20;
  localparam int RD_LSB  = 16;
  localparam int RT_MSB  = 15;
  localparam int RT_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [31:0] rf_a;
    logic [31:0] rf_b;
    logic [31:0] immed;
    logic [4:0]  dst;
    logic        valid;
  } id_ex_t;

endpackage

// File: rtl/register_file.sv
// 32x32 register file, two combinational read ports with
// write-through bypass, one synchronous write port, sync clear.
module register_file
  import decode_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra_addr,
  input  logic [4:0]  rb_addr,
  output logic [31:0] ra_data,
  output logic [31:0] rb_data,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic        wr_en;

  assign wr_en = we && (waddr != REG_ZERO);

  // Next register contents: clear on reset, else apply write-back.
  always_comb begin
    regs_d = regs_q;
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_d[i] = '0;
    end else if (wr_en) begin
      regs_d[waddr] = wdata;
    end
  end

  // Storage update.
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  // Read ports: R0 is hard zero, a same-cycle write wins over storage.
  always_comb begin
    ra_data = regs_q[ra_addr];
    rb_data = regs_q[rb_addr];
    if (wr_en && waddr == ra_addr) ra_data = wdata;
    if (wr_en && waddr == rb_addr) rb_data = wdata;
    if (ra_addr == REG_ZERO) ra_data = '0;
    if (rb_addr == REG_ZERO) rb_data = '0;
  end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode: register reads, immediate extension and the
// ID/EX operand latch with stall and flush.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] Instr,
  input  logic        Instr_valid,
  input  logic        RF_B_sel,
  input  logic [1:0]  ImmExt,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        WB_WrEn,
  input  logic [4:0]  WB_Addr,
  input  logic [31:0] WB_Data,
  output logic [31:0] RF_A,
  output logic [31:0] RF_B,
  output logic [31:0] Immed,
  output logic [4:0]  Dst_Addr,
  output logic        Out_valid
);

  logic [4:0]  ra_addr;
  logic [4:0]  rb_addr;
  logic [31:0] ra_data;
  logic [31:0] rb_data;
  logic [15:0] imm16;
  logic [31:0] imm_sext;
  logic [31:0] imm_ext;
  logic        unused_opcode;
  id_ex_t      id_ex_q;
  id_ex_t      id_ex_d;

  assign ra_addr = Instr[RS_MSB:RS_LSB];
  assign rb_addr = RF_B_sel ? Instr[RD_MSB:RD_LSB]
                            : Instr[RT_MSB:RT_LSB];
  assign imm16   = Instr[IMM_MSB:IMM_LSB];
  assign unused_opcode = ^Instr[OPC_MSB:OPC_LSB];

  register_file u_rf (
    .clk     (Clk),
    .rst     (Rst),
    .ra_addr (ra_addr),
    .rb_addr (rb_addr),
    .ra_data (ra_data),
    .rb_data (rb_data),
    .we      (WB_WrEn),
    .waddr   (WB_Addr),
    .wdata   (WB_Data)
  );

  // Immediate extension selected by ImmExt.
  always_comb begin
    imm_sext = {{16{imm16[15]}}, imm16};
    imm_ext  = '0;
    unique case (ImmExt)
      IMM_ZERO:     imm_ext = {16'h0000, imm16};
      IMM_SIGN:     imm_ext = imm_sext;
      IMM_SIGN_SH2: imm_ext = {imm_sext[29:0], 2'b00};
      IMM_HIGH:     imm_ext = {imm16, 16'h0000};
      default:      imm_ext = '0;
    endcase
  end

  // ID/EX next state: reset > flush > stall > load.
  always_comb begin
    id_ex_d = id_ex_q;
    if (Rst || Flush) begin
      id_ex_d = '0;
    end else if (!Stall) begin
      id_ex_d.rf_a  = ra_data;
      id_ex_d.rf_b  = rb_data;
      id_ex_d.immed = imm_ext;
      id_ex_d.dst   = Instr[RD_MSB:RD_LSB];
      id_ex_d.valid = Instr_valid;
    end
  end

  // ID/EX latch register.
  always_ff @(posedge Clk) begin
    id_ex_q <= id_ex_d;
  end

  assign RF_A      = id_ex_q.rf_a;
  assign RF_B      = id_ex_q.rf_b;
  assign Immed     = id_ex_q.immed;
  assign Dst_Addr  = id_ex_q.dst;
  assign Out_valid = id_ex_q.valid;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed cases then random
// traffic against a behavioural register-file/latch model.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] i;
    logic [4:0]  d;
    logic        v;
  } out_t;

  typedef struct packed {
    logic        rst;
    logic [31:0] instr;
    logic        valid;
    logic        bsel;
    logic [1:0]  immext;
    logic        stall;
    logic        flush;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } stim_t;

  logic        clk = 0;
  logic        Rst = 0;
  logic [31:0] Instr = 0;
  logic        Instr_valid = 0;
  logic        RF_B_sel = 0;
  logic [1:0]  ImmExt = 0;
  logic        Stall = 0;
  logic        Flush = 0;
  logic        WB_WrEn = 0;
  logic [4:0]  WB_Addr = 0;
  logic [31:0] WB_Data = 0;
  logic [31:0] RF_A;
  logic [31:0] RF_B;
  logic [31:0] Immed;
  logic [4:0]  Dst_Addr;
  logic        Out_valid;

  int compared = 0;
  int mismatched = 0;
  out_t  exp_q[$];
  string name_q[$];
  logic [31:0] mregs [32];
  out_t mlatch = '0;

  always #5 clk = ~clk;

  decode_stage dut (
    .Clk(clk), .Rst(Rst), .Instr(Instr), .Instr_valid(Instr_valid),
    .RF_B_sel(RF_B_sel), .ImmExt(ImmExt), .Stall(Stall),
    .Flush(Flush), .WB_WrEn(WB_WrEn), .WB_Addr(WB_Addr),
    .WB_Data(WB_Data), .RF_A(RF_A), .RF_B(RF_B), .Immed(Immed),
    .Dst_Addr(Dst_Addr), .Out_valid(Out_valid)
  );

  function automatic logic [31:0] mk(input logic [4:0] rs,
                                     input logic [4:0] rd,
                                     input logic [15:0] imm);
    return {6'h23, rs, rd, imm};
  endfunction

  function automatic logic [31:0] m_imm(input logic [1:0] m,
                                        input logic [15:0] x);
    int s;
    s = (x >= 16'h8000) ? int'(x) - 65536 : int'(x);
    case (m)
      2'd0: return 32'(int'(x));
      2'd1: return 32'(s);
      2'd2: return 32'(s * 4);
      default: return 32'(int'(x) * 65536);
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a,
                                         input stim_t s);
    if (a == 0) return 0;
    if (s.wen && s.waddr == a) return s.wdata;
    return mregs[a];
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic step(input stim_t s, input string nm);
    logic [4:0] ra;
    logic [4:0] rb;
    @(negedge clk);
    Rst = s.rst; Instr = s.instr; Instr_valid = s.valid;
    RF_B_sel = s.bsel; ImmExt = s.immext; Stall = s.stall;
    Flush = s.flush; WB_WrEn = s.wen; WB_Addr = s.waddr;
    WB_Data = s.wdata;
    ra = s.instr[25:21];
    rb = s.bsel ? s.instr[20:16] : s.instr[15:11];
    if (s.rst) begin
      mlatch = '0;
      for (int k = 0; k < 32; k++) mregs[k] = 0;
    end else begin
      if (s.flush) mlatch = '0;
      else if (!s.stall)
        mlatch = '{m_read(ra, s), m_read(rb, s),
                   m_imm(s.immext, s.instr[15:0]),
                   s.instr[20:16], s.valid};
      if (s.wen && s.waddr != 0) mregs[s.waddr] = s.wdata;
    end
    exp_q.push_back(mlatch);
    name_q.push_back(nm);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d,
                    input string nm);
    stim_t s;
    s = idle();
    s.wen = 1; s.waddr = a; s.wdata = d;
    step(s, nm);
  endtask

  // Monitor: compare presented latch outputs against the scoreboard.
  initial begin
    out_t e;
    out_t g;
    string n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        g = '{RF_A, RF_B, Immed, Dst_Addr, Out_valid};
        compared++;
        if (g !== e) begin
          mismatched++;
          $display("FAIL %s: got A=%h B=%h I=%h D=%0d V=%b exp A=%h B=%h I=%h D=%0d V=%b",
                   n, g.a, g.b, g.i, g.d, g.v, e.a, e.b, e.i, e.d, e.v);
        end
      end
    end
  end

  initial begin
    stim_t s;
    for (int k = 0; k < 32; k++) mregs[k] = 0;

    s = idle(); s.rst = 1;
    step(s, "reset");
    s = idle(); s.instr = mk(5, 0, {5'd7, 11'd0}); s.valid = 1;
    step(s, "rst_read");

    wr(3, 32'hDEADBEEF, "wr_r3");
    wr(0, 32'h1234, "wr_r0");
    s = idle(); s.instr = mk(3, 1, {5'd0, 11'h5}); s.valid = 1;
    step(s, "r0_read");

    s = idle(); s.instr = mk(9, 9, 16'h0); s.bsel = 1; s.valid = 1;
    s.wen = 1; s.waddr = 9; s.wdata = 32'hA5A5A5A5;
    step(s, "bypass");

    for (int m = 0; m < 4; m++) begin
      s = idle(); s.instr = mk(0, 2, 16'h8001); s.valid = 1;
      s.immext = 2'(m);
      step(s, $sformatf("imm_mode%0d", m));
    end

    wr(2, 32'h11, "wr_r2");
    s = idle(); s.instr = mk(2, 4, 16'h0); s.valid = 1;
    step(s, "load_11");
    s = idle(); s.instr = mk(3, 6, 16'h7777); s.valid = 1;
    s.stall = 1; s.wen = 1; s.waddr = 2; s.wdata = 32'h22;
    step(s, "stall1");
    s.wen = 0;
    step(s, "stall2");
    s.flush = 1;
    step(s, "stall_flush");
    s = idle(); s.instr = mk(2, 4, 16'h0); s.valid = 1;
    step(s, "reread_after_stall");

    wr(4, 32'h77, "wr_r4");
    s = idle(); s.rst = 1; s.stall = 1; s.flush = 1;
    s.wen = 1; s.waddr = 4; s.wdata = 32'h55;
    s.instr = mk(4, 4, 16'hFFFF); s.valid = 1;
    step(s, "mid_reset");
    s = idle(); s.instr = mk(4, 3, 16'h0); s.bsel = 1; s.valid = 1;
    step(s, "r4_after_reset");

    for (int n = 0; n < 400; n++) begin
      s.rst    = ($urandom_range(0, 63) == 0);
      s.instr  = $urandom;
      s.valid  = 1'($urandom);
      s.bsel   = 1'($urandom);
      s.immext = 2'($urandom);
      s.stall  = ($urandom_range(0, 4) == 0);
      s.flush  = ($urandom_range(0, 7) == 0);
      s.wen    = 1'($urandom);
      s.waddr  = ($urandom_range(0, 2) == 0) ? s.instr[25:21]
                                             : 5'($urandom);
      s.wdata  = $urandom;
      step(s, "random");
    end

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending, exp 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
